// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types; register index and pipeline sequencer states
package cpu_types_pkg;
   typedef logic [4:0] regbits_t;
   typedef enum logic [1:0] {RUN, DRAIN, HALTED} pipe_state_t;
endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: load-use compare between the EX-stage load and ID-stage sources
//   in  idex_dmemREN, idex_rt : EX-stage load and its destination
//   in  id_rs, id_rt          : ID-stage source registers
//   out load_use              : ID needs the loaded value next cycle (r0 never matches)
module hazard_detect
   import cpu_types_pkg::*;
(
   input  logic     idex_dmemREN,
   input  regbits_t idex_rt,
   input  regbits_t id_rs,
   input  regbits_t id_rt,
   output logic     load_use
);
   always_comb load_use = idex_dmemREN && (idex_rt != '0) && ((idex_rt == id_rs) || (idex_rt == id_rt));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer and halt drain for the five-stage pipeline
//   in  CLK, nRST (async, active-low)
//   in  ihit, dhit, exmem_dmemREN/WEN, idex_dmemREN, idex_rt, id_rs, id_rt, branch_taken, exmem_halt
//   out pc_en, {ifid,idex,exmem,memwb}_stall, {ifid,idex,exmem}_flush, halt_out
//   PIPECTRL_PERF_EN adds stall_count / flush_count (32-bit, saturating)
module pipeline_ctrl
   import cpu_types_pkg::*;
#(
   parameter int DRAIN_CYCLES = 2
) (
   input  logic     CLK,
   input  logic     nRST,
   input  logic     ihit,
   input  logic     dhit,
   input  logic     exmem_dmemREN,
   input  logic     exmem_dmemWEN,
   input  logic     idex_dmemREN,
   input  regbits_t idex_rt,
   input  regbits_t id_rs,
   input  regbits_t id_rt,
   input  logic     branch_taken,
   input  logic     exmem_halt,
   output logic     pc_en,
   output logic     ifid_stall,
   output logic     idex_stall,
   output logic     exmem_stall,
   output logic     memwb_stall,
   output logic     ifid_flush,
   output logic     idex_flush,
   output logic     exmem_flush,
   output logic     halt_out
`ifdef PIPECTRL_PERF_EN
   ,output logic [31:0] stall_count,
   output logic [31:0] flush_count
`endif
);
   localparam int CW = $clog2(DRAIN_CYCLES + 1);

   pipe_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          load_use, dmiss, branch_acc;

   hazard_detect u_hazard (
      .idex_dmemREN (idex_dmemREN),
      .idex_rt      (idex_rt),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .load_use     (load_use)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pc_en       = 1'b0;
      ifid_stall  = 1'b0;
      idex_stall  = 1'b0;
      exmem_stall = 1'b0;
      memwb_stall = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      halt_out    = 1'b0;
      branch_acc  = 1'b0;
      dmiss       = (exmem_dmemREN || exmem_dmemWEN) && !dhit;
      if (!nRST) begin
         {ifid_stall, idex_stall, exmem_stall, memwb_stall} = 4'hF;
      end else begin
         case (state_q)
            RUN: begin
               if (dmiss) begin
                  {ifid_stall, idex_stall, exmem_stall, memwb_stall} = 4'hF;
               end else if (exmem_halt) begin
                  {ifid_flush, idex_flush, exmem_flush} = 3'b111;
                  state_d = DRAIN;
                  cnt_d   = CW'(DRAIN_CYCLES - 1);
               end else if (branch_taken) begin
                  // squashes any load-use stall or fetch miss in the younger stages
                  pc_en      = 1'b1;
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
                  branch_acc = 1'b1;
               end else if (load_use) begin
                  ifid_stall = 1'b1;
                  idex_flush = 1'b1;
               end else if (!ihit) begin
                  ifid_flush = 1'b1;
               end else begin
                  pc_en = 1'b1;
               end
            end
            DRAIN: begin
               {ifid_flush, idex_flush, exmem_flush} = 3'b111;
               state_d = (cnt_q == '0) ? HALTED : DRAIN;
               cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
            end
            HALTED: begin
               {ifid_stall, idex_stall, exmem_stall, memwb_stall} = 4'hF;
               halt_out = 1'b1;
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef PIPECTRL_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = (state_q == RUN && !pc_en && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
      flush_cnt_d = (branch_acc && flush_cnt_q != '1) ? flush_cnt_q + 32'd1 : flush_cnt_q;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: scoreboard bench for pipeline_ctrl against a rule-level reference model
module tb_pipeline_ctrl;
   localparam int DC = 2;

   logic       CLK = 1'b0;
   logic       nRST = 1'b0;
   logic       ihit = 1'b0, dhit = 1'b0, exmem_dmemREN = 1'b0, exmem_dmemWEN = 1'b0;
   logic       idex_dmemREN = 1'b0, branch_taken = 1'b0, exmem_halt = 1'b0;
   logic [4:0] idex_rt = '0, id_rs = '0, id_rt = '0;
   logic       pc_en, ifid_stall, idex_stall, exmem_stall, memwb_stall;
   logic       ifid_flush, idex_flush, exmem_flush, halt_out;
`ifdef PIPECTRL_PERF_EN
   logic [31:0] stall_count, flush_count;
`endif

   pipeline_ctrl #(.DRAIN_CYCLES(DC)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .exmem_dmemREN(exmem_dmemREN), .exmem_dmemWEN(exmem_dmemWEN),
      .idex_dmemREN(idex_dmemREN), .idex_rt(idex_rt), .id_rs(id_rs), .id_rt(id_rt),
      .branch_taken(branch_taken), .exmem_halt(exmem_halt),
      .pc_en(pc_en), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
      .exmem_stall(exmem_stall), .memwb_stall(memwb_stall),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
      .halt_out(halt_out)
`ifdef PIPECTRL_PERF_EN
      ,.stall_count(stall_count), .flush_count(flush_count)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [8:0]  o;
      logic [31:0] sc;
      logic [31:0] fc;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   errs = 0, checks = 0;
   // edges since halt was accepted: -1 = running, 1..DC = draining, DC+1 = halted
   int   since = -1;
   int   m_sc = 0, m_fc = 0;

   // expected vector order: pc_en, ifid/idex/exmem/memwb stall, ifid/idex/exmem flush, halt_out
   task automatic cyc(input logic rn, ih, dh, er, ew, ir, input logic [4:0] rt, rs, irt,
                      input logic br, hl);
      logic [8:0] o;
      logic lu, miss, acc_h, acc_b;
      nRST = rn; ihit = ih; dhit = dh; exmem_dmemREN = er; exmem_dmemWEN = ew;
      idex_dmemREN = ir; idex_rt = rt; id_rs = rs; id_rt = irt; branch_taken = br; exmem_halt = hl;
      lu = ir && rt != 0 && (rt == rs || rt == irt);
      miss = (er || ew) && !dh;
      acc_h = 1'b0;
      acc_b = 1'b0;
      if (!rn)              o = 9'b0_1111_000_0;
      else if (since > DC)  o = 9'b0_1111_000_1;
      else if (since >= 1)  o = 9'b0_0000_111_0;
      else if (miss)        o = 9'b0_1111_000_0;
      else if (hl) begin    o = 9'b0_0000_111_0; acc_h = 1'b1; end
      else if (br) begin    o = 9'b1_0000_110_0; acc_b = 1'b1; end
      else if (lu)          o = 9'b0_1000_010_0;
      else if (!ih)         o = 9'b0_0000_100_0;
      else                  o = 9'b1_0000_000_0;
      q.push_back('{o, rn ? 32'(m_sc) : 32'd0, rn ? 32'(m_fc) : 32'd0});
      @(posedge CLK);
      if (!rn) begin
         since = -1; m_sc = 0; m_fc = 0;
      end else begin
         if (since < 0 && !o[8]) m_sc++;
         if (acc_b) m_fc++;
         if (acc_h) since = 1;
         else if (since >= 1 && since <= DC) since++;
      end
      #1;
   endtask

   always @(negedge CLK) begin
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if ({pc_en, ifid_stall, idex_stall, exmem_stall, memwb_stall,
              ifid_flush, idex_flush, exmem_flush, halt_out} !== e.o) begin
            errs++;
            $display("FAIL outputs t=%0t got %b want %b", $time,
                     {pc_en, ifid_stall, idex_stall, exmem_stall, memwb_stall,
                      ifid_flush, idex_flush, exmem_flush, halt_out}, e.o);
         end
`ifdef PIPECTRL_PERF_EN
         checks++;
         if (stall_count !== e.sc || flush_count !== e.fc) begin
            errs++;
            $display("FAIL perf t=%0t got stall=%0d flush=%0d want stall=%0d flush=%0d",
                     $time, stall_count, flush_count, e.sc, e.fc);
         end
`endif
      end
   end

   initial begin
      @(posedge CLK);
      #1;
      cyc(0,1,1,0,0,0,0,0,0,0,0);
      cyc(0,1,1,0,0,0,0,0,0,0,0);
      // load-use, self-clear, r0 never hazards
      cyc(1,1,1,0,0,1,5,5,0,0,0);
      cyc(1,1,1,0,0,0,5,5,0,0,0);
      cyc(1,1,1,0,0,1,0,0,0,0,0);
      // data miss for 3 cycles with branch pending, then hit
      repeat (3) cyc(1,1,0,1,0,0,0,0,0,1,0);
      cyc(1,1,1,1,0,0,0,0,0,1,0);
      cyc(1,1,0,0,1,0,0,0,0,0,0);
      // branch beats load-use and fetch miss
      cyc(1,0,1,0,0,1,7,0,7,1,0);
      // halt drain with ignored inputs, then held halted
      cyc(1,1,1,0,0,0,0,0,0,0,1);
      repeat (2) cyc(1,1,0,1,0,0,0,0,0,1,0);
      repeat (3) cyc(1,1,1,0,0,1,3,3,0,1,1);
      cyc(0,1,1,0,0,0,0,0,0,0,0);
      cyc(1,1,1,0,0,0,0,0,0,0,0);
      // reset mid-drain
      cyc(1,1,1,0,0,0,0,0,0,0,1);
      cyc(1,1,1,0,0,0,0,0,0,0,0);
      cyc(0,1,1,0,0,0,0,0,0,0,0);
      cyc(1,1,1,0,0,0,0,0,0,0,0);
      // 4 load-use stalls and 2 branches
      repeat (4) begin
         cyc(1,1,1,0,0,1,9,2,9,0,0);
         cyc(1,1,1,0,0,0,9,2,9,0,0);
      end
      repeat (2) cyc(1,1,1,0,0,0,0,0,0,1,0);
      cyc(0,1,1,0,0,0,0,0,0,0,0);
      cyc(1,1,1,0,0,0,0,0,0,0,0);
      for (int i = 0; i < 3000; i++) begin
         cyc(!(since > DC ? ($urandom_range(0,3) == 0) : ($urandom_range(0,199) == 0)),
             $urandom_range(0,9) < 8, $urandom_range(0,9) < 7,
             $urandom_range(0,9) < 2, $urandom_range(0,9) < 1,
             $urandom_range(0,9) < 4, 5'($urandom_range(0,3)),
             5'($urandom_range(0,3)), 5'($urandom_range(0,3)),
             $urandom_range(0,9) < 2, $urandom_range(0,39) == 0);
      end
      repeat (2) @(negedge CLK);
      if (q.size() != 0) begin
         errs++;
         $display("FAIL drain got %0d pending want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the five-stage pipeline. It decides every cycle whether the PC and each inter-stage latch (IF/ID, ID/EX, EX/MEM, MEM/WB) advance, hold or load a bubble. It arbitrates between cache misses, taken branches/jumps, load-use hazards and halt, and it sequences the halt drain. It sits beside the datapath and drives the `stall`/`flush` inputs of all four latches plus the PC enable.

## Interface
- `DRAIN_CYCLES`, default 2: cycles spent in DRAIN after halt reaches MEM, before HALTED.
- `CLK` in 1: system clock; all state updates on the rising edge.
- `nRST` in 1: asynchronous, active-low reset. One clock domain.
- `ihit` in 1: instruction fetch completes this cycle.
- `dhit` in 1: data access in MEM completes this cycle.
- `exmem_dmemREN`, `exmem_dmemWEN` in 1: MEM-stage load/store request.
- `idex_dmemREN` in 1: EX-stage instruction is a load.
- `idex_rt` in 5: EX-stage load destination register.
- `id_rs`, `id_rt` in 5: ID-stage source registers.
- `branch_taken` in 1: EX resolved a taken branch or jump; PC loads the target.
- `exmem_halt` in 1: halt instruction is in MEM.
- `pc_en` out 1: PC loads its next value.
- `ifid_stall`, `idex_stall`, `exmem_stall`, `memwb_stall` out 1: latch holds.
- `ifid_flush`, `idex_flush`, `exmem_flush` out 1: latch loads all-zero (bubble) at the next edge.
- `halt_out` out 1: processor halted, sticky.

## Operation
- States: RUN, DRAIN, HALTED.
- All outputs are combinational from state and inputs.
- While `nRST`=0:
  - state=RUN, drain counter=0.
  - Outputs forced to pc_en=0, all stalls=1, all flushes=0, halt_out=0.
- A flush takes precedence over a stall on the same latch. Only one of each pair is asserted.
- RUN, conditions evaluated in priority order:
  1. Data miss, `(exmem_dmemREN|exmem_dmemWEN)&~dhit`: freeze everything. pc_en=0, all four stalls=1, no flush.
  2. `exmem_halt`: pc_en=0, ifid_flush=1, idex_flush=1, exmem_flush=1, memwb advances. Load the drain counter with DRAIN_CYCLES-1. Next state DRAIN.
  3. `branch_taken`: pc_en=1, ifid_flush=1, idex_flush=1; EX/MEM and MEM/WB advance.
  4. Load-use, `idex_dmemREN & idex_rt!=0 & (idex_rt==id_rs | idex_rt==id_rt)`: pc_en=0, ifid_stall=1, idex_flush=1; later stages advance.
  5. `~ihit`: pc_en=0, ifid_flush=1; later stages advance.
  6. Otherwise: pc_en=1, no stalls, no flushes.
- Register 0 never causes a load-use hazard.
- Branch beats load-use on the same cycle: the stalled younger instruction is squashed anyway.
- A branch that coincides with `~ihit` still flushes IF/ID. pc_en=1 redirects fetch.
- DRAIN:
  - pc_en=0, ifid_flush=1, idex_flush=1, exmem_flush=1, memwb advances.
  - Counter decrements each cycle; when it reads 0, next state is HALTED.
  - `dhit`/`ihit`/`branch_taken` are ignored.
- HALTED: pc_en=0, all stalls=1, halt_out=1. Only `nRST` exits.
- Reset mid-DRAIN returns to RUN immediately and asynchronously.

## Timing
- Zero-cycle decision latency: outputs are valid in the same cycle as their inputs and take effect at the next rising edge.
- Load-use inserts exactly one bubble. In the next cycle the ID/EX latch holds a bubble (idex_dmemREN=0), so the hazard self-clears.
- A taken branch costs two bubbles (IF/ID and ID/EX).
- Halt to halt_out latency: DRAIN_CYCLES+1 edges after the first cycle with exmem_halt=1.
- A DRAIN_CYCLES value below 1 is illegal.

## Configuration
- `PIPECTRL_PERF_EN` defined:
  - Adds outputs `stall_count` out 32 and `flush_count` out 32, both reset to 0.
  - `stall_count` increments on every RUN cycle with pc_en=0.
  - `flush_count` increments on every `branch_taken` accepted in RUN.
  - Both saturate at 32'hFFFFFFFF and freeze in DRAIN and HALTED.
- Not defined: the ports and counters do not exist; all other behaviour is identical.

## Structure
- `cpu_types_pkg` gains:
  - `pipe_state_t` enum {RUN, DRAIN, HALTED}
  - `regbits_t` (5-bit), if not already present.
- One sub-module, `hazard_detect`: combinational load-use compare (idex_dmemREN, idex_rt, id_rs, id_rt → load_use).
- FSM, drain counter and optional perf counters live in `pipeline_ctrl`.

## Test plan
- idex_dmemREN=1, idex_rt=5, id_rs=5, ihit=1 → one cycle of pc_en=0, ifid_stall=1, idex_flush=1. Next cycle with idex_dmemREN=0 → pc_en=1. Repeat with idex_rt=0 → no stall.
- exmem_dmemREN=1, dhit=0 for 3 cycles then 1 → all stalls=1 and pc_en=0 for 3 cycles, then normal advance. Concurrent branch_taken=1 is ignored until dhit.
- branch_taken=1 with idex load-use active and ihit=0 → pc_en=1, ifid_flush=1, idex_flush=1, no stalls.
- exmem_halt=1, DRAIN_CYCLES=2 → flushes asserted for 3 cycles, halt_out=1 after the 3rd edge and held, all stalls=1 thereafter.
- nRST pulsed low during DRAIN → outputs immediately in reset pattern. After release, RUN and halt_out=0.
- With PIPECTRL_PERF_EN: 4 load-use stalls plus 2 branches → stall_count=4, flush_count=2. After reset both read 0.
